ram_init_seq: RTL and testbench

- Parametrised single-port-write / registered-read RAM for CNN weight and bias storage.
- Carries a built-in init sequencer. After reset it fills a configurable region with a linear ramp (INIT_START + k*INIT_STEP), one word per cycle.
- Replaces the reset-time for-loop fill with synthesizable sequential initialisation, a busy flag, and a qualified read-valid output.
- Sits between the CNN controller and the MAC array as the parameter store.

---
 rtl/ram_init_seq.sv | 70 +++++++
 tb/tb_ram_init_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ram_init_seq.sv
// ram_init_seq: single-port-write / registered-read parameter RAM with a ramp-fill init sequencer.
// Define RAM_BYPASS_EN to forward same-cycle write data on an address collision (write-first).
module ram_init_seq #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int INIT_BASE  = 10,
    parameter int INIT_LEN   = 50,
    parameter int INIT_START = -250,
    parameter int INIT_STEP  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] q,
    output logic              rd_valid,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {INIT, READY} state_t;
    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [31:0]       init_cnt;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_val;
    logic              init_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    always_comb begin
        init_last = (INIT_LEN == 0) || (init_cnt == 32'(INIT_LEN - 1));
        mem_we    = (state == INIT) ? (INIT_LEN != 0) : we;
        mem_addr  = (state == INIT) ? init_addr : wr_addr;
        mem_din   = (state == INIT) ? init_val : data;
    end
    // Storage has no reset so contents survive a sequencer restart
    always_ff @(posedge clk)
        if (mem_we) mem[mem_addr] <= mem_din;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_addr <= ADDR_W'(INIT_BASE);
            init_val  <= DATA_W'(INIT_START);
            busy      <= 1'b1;
            rd_valid  <= 1'b0;
            q         <= '0;
        end else if (state == INIT) begin
            init_cnt  <= init_cnt + 1;
            init_addr <= init_addr + 1'b1;
            init_val  <= init_val + DATA_W'(INIT_STEP);
            rd_valid  <= 1'b0;
            if (init_last) begin
                state <= READY;
                busy  <= 1'b0;
            end
        end else begin
            rd_valid <= re;
            if (re)
`ifdef RAM_BYPASS_EN
                q <= (we && wr_addr == rd_addr) ? data : mem[rd_addr];
`else
                q <= mem[rd_addr];
`endif
        end
    end
endmodule

// File: tb/tb_ram_init_seq.sv
// tb_ram_init_seq: randomized self-checking bench for ram_init_seq against an array-based model.
// Extra instances cover the zero-length fill and the address-wrap fill.
module tb_ram_init_seq;
    logic        clk = 0, reset = 1, we = 0, re = 0;
    logic [15:0] wr_addr = 0, data = 0, rd_addr = 0, q;
    logic        rd_valid, busy;
    logic        z_we = 0, z_re = 0;
    logic [15:0] z_wr_addr = 0, z_data = 0, z_rd_addr = 0, z_q;
    logic        z_rd_valid, z_busy;
    logic        w_re = 0;
    logic [3:0]  w_rd_addr = 0;
    logic [15:0] w_q;
    logic        w_rd_valid, w_busy;
    int          vecs = 0, errs = 0;
    logic [15:0] mdl [int];

    ram_init_seq dut (.clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .data(data),
        .re(re), .rd_addr(rd_addr), .q(q), .rd_valid(rd_valid), .busy(busy));
    ram_init_seq #(.INIT_LEN(0)) u_zero (.clk(clk), .reset(reset), .we(z_we), .wr_addr(z_wr_addr),
        .data(z_data), .re(z_re), .rd_addr(z_rd_addr), .q(z_q), .rd_valid(z_rd_valid), .busy(z_busy));
    ram_init_seq #(.ADDR_W(4), .INIT_BASE(14), .INIT_LEN(4)) u_wrap (.clk(clk), .reset(reset),
        .we(1'b0), .wr_addr(4'd0), .data(16'd0), .re(w_re), .rd_addr(w_rd_addr), .q(w_q),
        .rd_valid(w_rd_valid), .busy(w_busy));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ramp(input int k);
        return 16'(-250 + 10 * k);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset for 3 cycles, then track busy; abort_at>0 stops early to test a mid-fill reset
    task automatic init_run(input int abort_at, input bit poke);
        int n = 0, zn = 0, wn = 0;
        reset = 1;
        repeat (3) step();
        check("rst_q", q, 16'h0);
        check("rst_valid", {15'b0, rd_valid}, 16'h0);
        check("rst_busy", {15'b0, busy}, 16'h1);
        reset = 0;
        while (busy && n < 200) begin
            n++;
            if (z_busy) zn++;
            if (w_busy) wn++;
            check("init_valid", {15'b0, rd_valid}, 16'h0);
            if (abort_at > 0 && n == abort_at) return;
            we = poke && n == 3; re = poke && n == 3;
            wr_addr = 12; rd_addr = 12; data = 16'hAAAA;
            step();
        end
        we = 0; re = 0;
        check("busy_len", 16'(n), 16'd50);
        check("zero_busy_len", 16'(zn), 16'd1);
        check("wrap_busy_len", 16'(wn), 16'd4);
        for (int k = 0; k < 50; k++) mdl[10 + k] = ramp(k);
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        rd_addr = a; re = 1;
        step();
        re = 0;
        check({tag, "_valid"}, {15'b0, rd_valid}, 16'h1);
        check(tag, q, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        wr_addr = a; data = d; we = 1;
        step();
        we = 0;
        mdl[int'(a)] = d;
    endtask

    initial begin
        logic [15:0] exp, last_q;
        init_run(0, 1);
        rd("fill_10", 10, 16'hFF06);
        rd("fill_11", 11, 16'hFF10);
        rd("fill_59", 59, 16'h00F0);
        rd("init_drop_12", 12, 16'hFF1A);
        wr(5, 16'h1234);
        rd("rw_5", 5, 16'h1234);
        step();
        check("idle_valid", {15'b0, rd_valid}, 16'h0);
        check("idle_hold", q, 16'h1234);
        // Same-cycle collision at address 20
        wr_addr = 20; rd_addr = 20; data = 16'h1234; we = 1; re = 1;
        step();
        we = 0; re = 0; mdl[20] = 16'h1234;
`ifdef RAM_BYPASS_EN
        check("collide", q, 16'h1234);
`else
        check("collide", q, 16'hFF6A);
`endif
        rd("after_collide", 20, 16'h1234);
        last_q = q;
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ra, wa, d;
            logic        w, r;
            w = 1'($urandom); r = 1'($urandom);
            wa = 16'($urandom_range(63)); ra = 16'($urandom_range(63)); d = 16'($urandom);
            if (!mdl.exists(int'(ra))) ra = 10 + ra % 50;
            exp = mdl[int'(ra)];
`ifdef RAM_BYPASS_EN
            if (w && wa == ra) exp = d;
`endif
            we = w; re = r; wr_addr = wa; rd_addr = ra; data = d;
            step();
            if (w) mdl[int'(wa)] = d;
            if (r) last_q = exp;
            check("rand_valid", {15'b0, rd_valid}, {15'b0, r});
            check("rand_q", q, last_q);
        end
        we = 0; re = 0;
        wr(5, 16'h1234);
        wr(20, 16'h5555);
        z_wr_addr = 10; z_data = 16'h5A5A; z_we = 1;
        step();
        z_we = 0;
        rd("pre_abort", 5, 16'h1234);
        init_run(20, 0);
        init_run(0, 0);
        rd("refill_10", 10, 16'hFF06);
        rd("refill_20", 20, 16'hFF6A);
        rd("refill_59", 59, 16'h00F0);
        rd("kept_5", 5, 16'h1234);
        z_rd_addr = 10; z_re = 1;
        step();
        z_re = 0;
        check("zero_nowrite_valid", {15'b0, z_rd_valid}, 16'h1);
        check("zero_nowrite", z_q, 16'h5A5A);
        for (int k = 0; k < 4; k++) begin
            w_rd_addr = 4'(14 + k); w_re = 1;
            step();
            w_re = 0;
            check("wrap_valid", {15'b0, w_rd_valid}, 16'h1);
            check("wrap_q", w_q, ramp(k));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
